cordic_rotate_iter: RTL and testbench
=====================================

# cordic_rotate_iter

Iterative rotation-mode CORDIC engine that rotates a signed 32-bit vector (x, y) by angle z, one micro-rotation per clock. It sits directly downstream of the 32-bit ripple adder block `fullAdder32b`. It instantiates three of those adders, one each for x, y and z, and time-multiplexes them across iterations. It is the core datapath stage of the CORDIC processor: a start/done handshake on one side, registered results on the other.

## Interface
Parameters:
- `ITER`, default 16: number of micro-rotations. Legal range 1..30.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `x_in`  in  32  signed x operand, two's complement.
- `y_in`  in  32  signed y operand, two's complement.
- `z_in`  in  32  signed angle, Q3.29 radians.
- `busy`  out  1  high from the accepting edge through the done cycle inclusive.
- `done`  out  1  single-cycle pulse; results valid.
- `x_out`  out  32  rotated x, gain-scaled.
- `y_out`  out  32  rotated y, gain-scaled.
- `z_out`  out  32  residual angle, Q3.29.

## Operation
- States: IDLE, PRE (present only with the macro), ROT, OUT.
- IDLE:
  - On `start`=1, register `x_in`, `y_in` and `z_in`, and clear the iteration counter i to 0.
  - Next state is PRE if compiled in, otherwise ROT.
- ROT performs one micro-rotation per cycle for i = 0..ITER-1:
  - Direction d = +1 if z ≥ 0 (sign bit 0), else -1.
  - x ← x − d·(y >>> i)
  - y ← y + d·(x >>> i)
  - z ← z − d·atan(2^-i)
  - `>>>` is an arithmetic shift, and all three updates use the pre-update values.
  - After i = ITER-1 completes, go to OUT.
- Subtraction is done as a + ~b with cin=1 through `fullAdder32b`. cout is discarded, so all arithmetic wraps modulo 2^32 with no saturation.
- Arctan table: constant ROM of atan(2^-i) in Q3.29, rounded to nearest.
  - Entry 0 = 0x1921FB54 (π/4).
  - Entries at index ≥ ITER are unused.
- OUT: load `x_out`, `y_out` and `z_out` from the working registers, pulse `done`, then return to IDLE.
- Output gain: ITER=16 gives ≈1.6467602. There is no gain compensation.
- Outputs hold their last values until the next OUT state.
- `start` while `busy`=1 is ignored, with no queuing.
- `start` may be held high; a new operation begins on the first edge after returning to IDLE.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - `busy`=0, `done`=0.
  - `x_out`=`y_out`=`z_out`=0.
  - Working registers and counter are cleared.
- Reset mid-operation aborts with no `done` pulse. The outputs read 0, not the previous results.
- Latency, measured from the edge that samples `start`=1:
  - `done`=1 during the cycle after edge ITER+1 (edge ITER+2 with the macro).
  - Outputs update on that same edge.
- `busy` rises on the accepting edge and falls on the edge that ends the `done` cycle.
- Back-to-back throughput: one result per ITER+2 cycles (ITER+3 with the macro).

## Configuration
- `CORDIC_QUAD_EN` defined: the PRE state performs quadrant pre-rotation for one cycle.
  - If z > π/2 (0x3243F6A8): x ← −y, y ← x, z ← z − 0x3243F6A8.
  - If z < −π/2: x ← y, y ← −x, z ← z + 0x3243F6A8.
  - Otherwise the values pass unchanged.
  - Legal z range is [−π, π].
- Not defined: the PRE state and its cycle are removed.
  - Legal z range is [−π/2, π/2].
  - Inputs outside that range still run deterministically, but the results are not meaningful.

## Test plan
- Use ITER=16 for all scenarios. Tolerance is ±2^14 LSB on x/y and ±2^8 on z.
- Scenario 1: x=0x10000000, y=0, z=0 → `done` after 17 cycles; x_out≈0x1A592123, y_out≈0, z_out≈0.
- Scenario 2: x=0x10000000, y=0, z=0x3243F6A8 (π/2) → x_out≈0, y_out≈0x1A592123.
- Scenario 3: start pulses again during ROT → ignored; exactly one `done`; `busy` stays high throughout.
- Scenario 4: assert `rst` at iteration 8 → `busy`=`done`=0 and outputs=0 immediately; a fresh start completes normally.
- Scenario 5 (with `CORDIC_QUAD_EN`): x=0x10000000, y=0, z=0x6487ED51 (π) → `done` after 18 cycles; x_out≈−0x1A592123, y_out≈0.
- Scenario 6: hold `start` high continuously → results repeat every 18 cycles; `done` is never asserted on two consecutive cycles.

Source files
------------

// File: rtl/cordic_rotate_iter.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock through three shared ripple adders.
// Optional quadrant pre-rotation stage is compiled in with `define CORDIC_QUAD_EN.

module fullAdder32b (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  logic w_c;

  always_comb begin
    w_c   = i_cin;
    o_sum = '0;
    for (int k = 0; k < 32; k++) begin
      o_sum[k] = i_a[k] ^ i_b[k] ^ w_c;
      w_c      = (i_a[k] & i_b[k]) | (w_c & (i_a[k] ^ i_b[k]));
    end
    o_cout = w_c;
  end
endmodule

module cordic_rotate_iter #(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic [31:0] z_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] x_out,
  output logic [31:0] y_out,
  output logic [31:0] z_out,
  output logic [1:0]  o_dbg_state
);
  // Handshake: start is sampled on a rising edge while the FSM sits in IDLE;
  // busy is high from that edge until the edge ending the done cycle, and
  // done is a one-cycle pulse during which x_out/y_out/z_out are valid.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef CORDIC_QUAD_EN
    S_PRE  = 2'd1,
`endif
    S_ROT  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic [4:0] LAST = 5'(ITER - 1);

`ifdef CORDIC_QUAD_EN
  localparam logic signed [31:0] HALF_PI     = 32'sh3243F6A8;
  localparam logic signed [31:0] NEG_HALF_PI = -32'sh3243F6A8;
`endif

  // atan(2^-i) in Q3.29, rounded to nearest
  function automatic logic [31:0] atan_rom(input logic [4:0] idx);
    case (idx)
      5'd0:  return 32'h1921FB54;
      5'd1:  return 32'h0ED63383;
      5'd2:  return 32'h07D6DD7E;
      5'd3:  return 32'h03FAB753;
      5'd4:  return 32'h01FF55BB;
      5'd5:  return 32'h00FFEAAE;
      5'd6:  return 32'h007FFD55;
      5'd7:  return 32'h003FFFAB;
      5'd8:  return 32'h001FFFF5;
      5'd9:  return 32'h000FFFFF;
      5'd10: return 32'h00080000;
      5'd11: return 32'h00040000;
      5'd12: return 32'h00020000;
      5'd13: return 32'h00010000;
      5'd14: return 32'h00008000;
      5'd15: return 32'h00004000;
      5'd16: return 32'h00002000;
      5'd17: return 32'h00001000;
      5'd18: return 32'h00000800;
      5'd19: return 32'h00000400;
      5'd20: return 32'h00000200;
      5'd21: return 32'h00000100;
      5'd22: return 32'h00000080;
      5'd23: return 32'h00000040;
      5'd24: return 32'h00000020;
      5'd25: return 32'h00000010;
      5'd26: return 32'h00000008;
      5'd27: return 32'h00000004;
      5'd28: return 32'h00000002;
      5'd29: return 32'h00000001;
      default: return 32'h00000000;
    endcase
  endfunction

  state_t      r_state;
  logic [31:0] r_x, r_y, r_z;
  logic [4:0]  r_iter;

  logic        w_dir_pos;
  logic [31:0] w_x_sh, w_y_sh, w_atan;
  logic [31:0] w_x_a, w_x_b, w_y_a, w_y_b, w_z_a, w_z_b;
  logic        w_x_c, w_y_c, w_z_c;
  logic [31:0] w_x_sum, w_y_sum, w_z_sum;
  logic [2:0]  w_cout_unused;

  assign w_dir_pos   = ~r_z[31];
  assign w_x_sh      = $signed(r_x) >>> r_iter;
  assign w_y_sh      = $signed(r_y) >>> r_iter;
  assign w_atan      = atan_rom(r_iter);
  assign o_dbg_state = r_state;

  // Adder operand steering; subtraction is a + ~b with carry-in 1
  always_comb begin
    w_x_a = r_x; w_x_b = '0; w_x_c = 1'b0;
    w_y_a = r_y; w_y_b = '0; w_y_c = 1'b0;
    w_z_a = r_z; w_z_b = '0; w_z_c = 1'b0;
    case (r_state)
      S_ROT: begin
        w_x_b = w_dir_pos ? ~w_y_sh : w_y_sh;
        w_x_c = w_dir_pos;
        w_y_b = w_dir_pos ? w_x_sh : ~w_x_sh;
        w_y_c = ~w_dir_pos;
        w_z_b = w_dir_pos ? ~w_atan : w_atan;
        w_z_c = w_dir_pos;
      end
`ifdef CORDIC_QUAD_EN
      S_PRE: begin
        if ($signed(r_z) > HALF_PI) begin
          w_x_a = '0;  w_x_b = ~r_y; w_x_c = 1'b1;
          w_y_a = r_x;
          w_z_b = ~HALF_PI; w_z_c = 1'b1;
        end else if ($signed(r_z) < NEG_HALF_PI) begin
          w_x_a = r_y;
          w_y_a = '0;  w_y_b = ~r_x; w_y_c = 1'b1;
          w_z_b = HALF_PI;
        end
      end
`endif
      default: ;
    endcase
  end

  fullAdder32b u_add_x (.i_a(w_x_a), .i_b(w_x_b), .i_cin(w_x_c), .o_sum(w_x_sum), .o_cout(w_cout_unused[0]));
  fullAdder32b u_add_y (.i_a(w_y_a), .i_b(w_y_b), .i_cin(w_y_c), .o_sum(w_y_sum), .o_cout(w_cout_unused[1]));
  fullAdder32b u_add_z (.i_a(w_z_a), .i_b(w_z_b), .i_cin(w_z_c), .o_sum(w_z_sum), .o_cout(w_cout_unused[2]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_iter  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      x_out   <= '0;
      y_out   <= '0;
      z_out   <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x    <= x_in;
            r_y    <= y_in;
            r_z    <= z_in;
            r_iter <= '0;
            busy   <= 1'b1;
`ifdef CORDIC_QUAD_EN
            r_state <= S_PRE;
`else
            r_state <= S_ROT;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
`ifdef CORDIC_QUAD_EN
        S_PRE: begin
          r_x     <= w_x_sum;
          r_y     <= w_y_sum;
          r_z     <= w_z_sum;
          r_state <= S_ROT;
        end
`endif
        S_ROT: begin
          r_x <= w_x_sum;
          r_y <= w_y_sum;
          r_z <= w_z_sum;
          if (r_iter == LAST) r_state <= S_OUT;
          else                r_iter  <= r_iter + 5'd1;
        end
        S_OUT: begin
          x_out   <= r_x;
          y_out   <= r_y;
          z_out   <= r_z;
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_rotate_iter.sv
// Directed scoreboard bench for cordic_rotate_iter (ITER=16); add the CORDIC_QUAD_EN
// define to also exercise the quadrant pre-rotation vector.

module tb_cordic_rotate_iter;
  localparam int ITER = 16;
`ifdef CORDIC_QUAD_EN
  localparam int LAT = ITER + 2;
`else
  localparam int LAT = ITER + 1;
`endif
  localparam int PER   = LAT + 1;
  localparam int TOL   = 1 << 14;
  localparam int GAINX = 442048803;   // 0x1A592123 = K * 2^28
  localparam int DIAG  = 312575706;   // K * 2^28 * cos(pi/4)

  logic        clk, rst, start;
  logic [31:0] x_in, y_in, z_in;
  logic        busy, done;
  logic [31:0] x_out, y_out, z_out;
  logic [1:0]  dbg_state;

  cordic_rotate_iter #(.ITER(ITER)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(busy), .done(done),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .o_dbg_state(dbg_state)
  );

  // clock / reset / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [31:0] exp_x_q[$], exp_y_q[$], exp_z_q[$], exp_c_q[$];
  int n_vec = 0, n_chk = 0, n_err = 0, n_done = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input logic [31:0] act, input logic [31:0] exp);
    int diff;
    n_chk++;
    diff = $signed(act - exp);
    if (diff > TOL || diff < -TOL) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, $signed(act), $signed(exp), TOL);
    end
  endtask

  // monitor: pops one expected result per done pulse
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        n_done++;
        chk("done_back_to_back", {31'd0, prev_done}, 32'd0);
        chk("busy_during_done", {31'd0, busy}, 32'd1);
        if (exp_x_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending result", cyc);
        end else begin
          chk_tol("x_out", x_out, exp_x_q.pop_front());
          chk_tol("y_out", y_out, exp_y_q.pop_front());
          chk("z_out", z_out, exp_z_q.pop_front());
          chk("done_cycle", cyc, exp_c_q.pop_front());
        end
      end
      prev_done = done;
    end
  end

  // drivers
  task automatic push_exp(input logic [31:0] ex, ey, ez, input int c);
    exp_x_q.push_back(ex);
    exp_y_q.push_back(ey);
    exp_z_q.push_back(ez);
    exp_c_q.push_back(c);
  endtask

  task automatic issue(input logic [31:0] xi, yi, zi, input bit push,
                       input logic [31:0] ex, ey, ez);
    @(negedge clk);
    x_in = xi; y_in = yi; z_in = zi; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) push_exp(ex, ey, ez, cyc + LAT);
    n_vec++;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while ((busy || exp_x_q.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_chk++;
      n_err++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d expected idle within 200 cycles",
               busy, exp_x_q.size());
      exp_x_q.delete(); exp_y_q.delete(); exp_z_q.delete(); exp_c_q.delete();
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_x_out"}, x_out, 32'd0);
    chk({tag, "_y_out"}, y_out, 32'd0);
    chk({tag, "_z_out"}, z_out, 32'd0);
    chk({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    int done_before, c0;
    rst = 1'b1; start = 1'b0; x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;

    // basic vectors: z residuals are exact, x/y within tolerance
    issue(32'h10000000, 32'h0, 32'h0,        1, GAINX, 32'd0, 32'd9447);
    wait_idle();
    issue(32'h10000000, 32'h0, 32'h3243F6A8, 1, 32'd0, GAINX, -32'sd9447);
    wait_idle();
    issue(32'h10000000, 32'h0, 32'h1921FB54, 1, DIAG, DIAG, -32'sd8339);
    wait_idle();
    issue(32'h10000000, 32'h0, -32'sh1921FB54, 1, DIAG, -DIAG, -32'sd8339);
    wait_idle();
    issue(32'h0, 32'h10000000, 32'h0,        1, 32'd0, GAINX, 32'd9447);
    wait_idle();

    // start pulse while busy is ignored
    done_before = n_done;
    issue(32'h10000000, 32'h0, 32'h3243F6A8, 1, 32'd0, GAINX, -32'sd9447);
    repeat (4) begin
      @(negedge clk);
      chk("busy_in_rot", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    x_in = 32'h7FFFFFFF; y_in = 32'h12345678; z_in = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_ignored_start", {31'd0, busy}, 32'd1);
    wait_idle();
    repeat (ITER + 4) @(negedge clk);
    chk("single_done", n_done - done_before, 32'd1);

    // asynchronous reset at iteration 8
    issue(32'h10000000, 32'h0, 32'h0, 0, '0, '0, '0);
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_cleared("abort");
    @(negedge clk);
    rst = 1'b0;
    issue(32'h10000000, 32'h0, 32'h0, 1, GAINX, 32'd0, 32'd9447);
    wait_idle();

`ifdef CORDIC_QUAD_EN
    issue(32'h10000000, 32'h0, 32'h6487ED51, 1, -GAINX, 32'd0, -32'sd9446);
    wait_idle();
`endif

    // start held high: three results, one every PER cycles
    @(negedge clk);
    x_in = 32'h10000000; y_in = 32'h0; z_in = 32'h0; start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int k = 0; k < 3; k++) push_exp(GAINX, 32'd0, 32'd9447, c0 + LAT + k * PER);
    n_vec += 3;
    repeat (3 * PER - 1) @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000 time units");
    $fatal(1);
  end
endmodule
